// File: rtl/rst_set_seq_pkg.sv
// Shared types and defaults for the reset/preset sequencer.
// The counter-width helper sizes the one counter that serves both the hold and guard phases.
package rst_set_seq_pkg;

  typedef enum logic [2:0] {
    ST_RESET    = 3'd0,
    ST_HOLD_RST = 3'd1,
    ST_HOLD_SET = 3'd2,
    ST_GUARD    = 3'd3,
    ST_RUN      = 3'd4
  } state_t;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int MIN_WIDTH_DEF   = 4;
  localparam int GUARD_DEF       = 2;

  function automatic int cnt_w(input int min_width, input int guard_cycles);
    int max_v;
    max_v = (min_width > guard_cycles) ? min_width : guard_cycles;
    return $clog2(max_v + 1);
  endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// Reset-release synchronizer. It is cleared asynchronously and shifts in ones on each clock edge.
// o_sync_next is the value the last stage loads on the next edge, so a consumer can act on that same edge.
module rst_sync_chain #(
  parameter int STAGES = 2
) (
  input  logic i_ck,
  input  logic i_rn,
  output logic o_sync,
  output logic o_sync_next
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge i_ck or negedge i_rn) begin
    if (!i_rn) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], 1'b1};
    end
  end

  assign o_sync      = r_chain[STAGES-1];
  assign o_sync_next = r_chain[STAGES-2];

endmodule

// File: rtl/rst_set_seq.sv
// Drives the RN/SN pins of a DFFRS bank. Reset asserts asynchronously and releases synchronously.
// Each assertion has a fixed width and a recovery guard, and RN/SN are never low together.
module rst_set_seq
  import rst_set_seq_pkg::*;
#(
  parameter int SYNC_STAGES  = SYNC_STAGES_DEF,
  parameter int MIN_WIDTH    = MIN_WIDTH_DEF,
  parameter int GUARD_CYCLES = GUARD_DEF
) (
  input  logic CK,
  input  logic RN,
  input  logic SW_RST_REQ,
  input  logic PRESET_REQ,
  output logic RN_OUT,
  output logic SN_OUT,
  output logic CK_EN,
  output logic RST_DONE,
  output logic REQ_DROP
);

  localparam int CNT_W = cnt_w(MIN_WIDTH, GUARD_CYCLES);
  localparam logic [CNT_W-1:0] MIN_LOAD   = CNT_W'(MIN_WIDTH - 1);
  localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_rn_out;
  logic             r_sn_out;
  logic             r_ck_en;
  logic             r_rst_done;
  logic             r_req_drop;
  logic             w_drop_next;
  logic             w_req_any;
  logic             w_sync;
  logic             w_sync_next;
  logic             w_cnt_zero;

  rst_sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_ck        (CK),
    .i_rn        (RN),
    .o_sync      (w_sync),
    .o_sync_next (w_sync_next)
  );

  assign w_req_any  = SW_RST_REQ | PRESET_REQ;
  assign w_cnt_zero = (r_cnt == '0);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_drop_next  = 1'b0;
    case (r_state)
      ST_RESET: begin
        // Leave on the edge where the last synchronizer stage turns 1.
        if (w_sync | w_sync_next) begin
          w_state_next = ST_HOLD_RST;
          w_cnt_next   = MIN_LOAD;
        end
        w_drop_next = w_req_any;
      end
      ST_HOLD_RST, ST_HOLD_SET: begin
        if (w_cnt_zero) begin
          w_state_next = ST_GUARD;
          w_cnt_next   = GUARD_LOAD;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
        w_drop_next = w_req_any;
      end
      ST_GUARD: begin
        if (w_cnt_zero) begin
          w_state_next = ST_RUN;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
        w_drop_next = w_req_any;
      end
      ST_RUN: begin
        // When both requests arrive together, reset takes priority and the preset is reported as dropped.
        if (SW_RST_REQ) begin
          w_state_next = ST_HOLD_RST;
          w_cnt_next   = MIN_LOAD;
          w_drop_next  = PRESET_REQ;
        end else if (PRESET_REQ) begin
          w_state_next = ST_HOLD_SET;
          w_cnt_next   = MIN_LOAD;
        end
      end
      default: begin
        w_state_next = ST_RESET;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state, so every output is a flop.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_state    <= ST_RESET;
      r_cnt      <= '0;
      r_rn_out   <= 1'b0;
      r_sn_out   <= 1'b1;
      r_ck_en    <= 1'b0;
      r_rst_done <= 1'b0;
      r_req_drop <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_rn_out   <= (w_state_next != ST_RESET) && (w_state_next != ST_HOLD_RST);
      r_sn_out   <= (w_state_next != ST_HOLD_SET);
      r_ck_en    <= (w_state_next == ST_RUN);
      r_rst_done <= r_rst_done | (w_state_next == ST_RUN);
      r_req_drop <= w_drop_next;
    end
  end

  assign RN_OUT   = r_rn_out;
  assign SN_OUT   = r_sn_out;
  assign CK_EN    = r_ck_en;
  assign RST_DONE = r_rst_done;
  assign REQ_DROP = r_req_drop;

endmodule

// File: tb/tb_rst_set_seq.sv
// Bench for rst_set_seq: a directed scenario followed by random requests with RN glitches.
// The reference model tracks, for each output, the edge at which it next returns high.
module tb_rst_set_seq;

  localparam int S  = 2;
  localparam int MW = 4;
  localparam int G  = 2;

  logic CK = 1'b0;
  logic RN = 1'b1;
  logic SW_RST_REQ = 1'b0;
  logic PRESET_REQ = 1'b0;
  logic RN_OUT, SN_OUT, CK_EN, RST_DONE, REQ_DROP;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, counted in edges since RN last rose.
  bit rn_hi = 1'b0;
  int e = 0;
  int rst_rise = 0, set_rise = 0, run_at = 0;
  bit m_done = 1'b0, m_drop = 1'b0;
  bit x_rn_out, x_sn_out, x_ck_en;

  // Pulse-width monitor state.
  bit prev_rn_out = 1'b0, prev_sn_out = 1'b1;
  bit rn_arm = 1'b0, sn_arm = 1'b0;
  int rn_len = 0, sn_len = 0;

  rst_set_seq dut (
    .CK         (CK),
    .RN         (RN),
    .SW_RST_REQ (SW_RST_REQ),
    .PRESET_REQ (PRESET_REQ),
    .RN_OUT     (RN_OUT),
    .SN_OUT     (SN_OUT),
    .CK_EN      (CK_EN),
    .RST_DONE   (RST_DONE),
    .REQ_DROP   (REQ_DROP)
  );

  always #5 CK = ~CK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d (edge %0d)", tag, got, exp, e);
    end
  endtask

  task automatic model_release();
    rn_hi    = 1'b1;
    e        = 0;
    rst_rise = S + MW;
    set_rise = 0;
    run_at   = S + MW + G;
  endtask

  task automatic model_edge(input bit sw, input bit pre);
    bit running;
    m_drop = 1'b0;
    if (!rn_hi) return;
    e++;
    running = (e - 1) >= run_at;
    if (running) begin
      if (sw) begin
        rst_rise = e + MW;
        run_at   = e + MW + G;
        m_drop   = pre;
      end else if (pre) begin
        set_rise = e + MW;
        run_at   = e + MW + G;
      end
    end else begin
      m_drop = sw | pre;
    end
  endtask

  task automatic compare_all();
    if (!rn_hi) begin
      x_rn_out = 1'b0; x_sn_out = 1'b1; x_ck_en = 1'b0;
      m_done = 1'b0; m_drop = 1'b0;
    end else begin
      x_rn_out = (e >= rst_rise);
      x_sn_out = (e >= set_rise);
      x_ck_en  = (e >= run_at);
      m_done   = m_done | x_ck_en;
    end
    check("rn_out", RN_OUT, x_rn_out);
    check("sn_out", SN_OUT, x_sn_out);
    check("ck_en", CK_EN, x_ck_en);
    check("rst_done", RST_DONE, m_done);
    check("req_drop", REQ_DROP, m_drop);
    check("rn_or_sn", RN_OUT | SN_OUT, 1);
    if (!rn_hi) begin
      rn_arm = 1'b0;
      sn_arm = 1'b0;
    end else begin
      if (prev_rn_out && !RN_OUT) begin rn_arm = 1'b1; rn_len = 0; end
      if (rn_arm && !RN_OUT) rn_len++;
      if (rn_arm && RN_OUT) begin check("rn_pulse_w", rn_len, MW); rn_arm = 1'b0; end
      if (prev_sn_out && !SN_OUT) begin sn_arm = 1'b1; sn_len = 0; end
      if (sn_arm && !SN_OUT) sn_len++;
      if (sn_arm && SN_OUT) begin check("sn_pulse_w", sn_len, MW); sn_arm = 1'b0; end
    end
    prev_rn_out = RN_OUT;
    prev_sn_out = SN_OUT;
  endtask

  task automatic step(input bit sw, input bit pre);
    SW_RST_REQ = sw;
    PRESET_REQ = pre;
    @(posedge CK);
    model_edge(sw, pre);
    #1;
    compare_all();
  endtask

  task automatic rn_abort();
    #2 RN = 1'b0;
    rn_hi = 1'b0;
    #1;
    compare_all();
  endtask

  task automatic rn_release();
    #2 RN = 1'b1;
    model_release();
  endtask

  initial begin
    // Drive a real falling edge on RN so the async clear is exercised.
    #1 RN = 1'b0;
    #2;
    compare_all();
    repeat (3) step(1'b0, 1'b0);
    rn_release();

    for (int idx = 1; idx <= 49; idx++) begin
      step(idx == 20 || idx == 40, idx == 30 || idx == 40 || idx == 42 || idx == 48);
      case (idx)
        5:  check("pu_rn_low_e5", RN_OUT, 0);
        6:  check("pu_rn_rise_e6", RN_OUT, 1);
        7:  check("pu_cken_low_e7", CK_EN, 0);
        8:  begin check("pu_cken_e8", CK_EN, 1); check("pu_done_e8", RST_DONE, 1); end
        23: check("sw_rn_low_e23", RN_OUT, 0);
        24: check("sw_rn_rise_e24", RN_OUT, 1);
        25: check("sw_cken_low_e25", CK_EN, 0);
        26: begin check("sw_cken_e26", CK_EN, 1); check("sw_done_e26", RST_DONE, 1); end
        33: check("ps_sn_low_e33", SN_OUT, 0);
        34: check("ps_sn_rise_e34", SN_OUT, 1);
        36: check("ps_cken_e36", CK_EN, 1);
        40: begin check("col_drop_e40", REQ_DROP, 1); check("col_sn_e40", SN_OUT, 1); end
        42: check("hold_drop_e42", REQ_DROP, 1);
        49: check("hs_sn_low_e49", SN_OUT, 0);
        default: ;
      endcase
    end

    rn_abort();
    check("abort_rn_out", RN_OUT, 0);
    check("abort_sn_out", SN_OUT, 1);
    check("abort_done", RST_DONE, 0);
    repeat (2) step(1'b0, 1'b0);
    rn_release();
    for (int idx = 1; idx <= 10; idx++) begin
      step(1'b0, 1'b0);
      if (idx == 6) check("rpu_rn_rise_e6", RN_OUT, 1);
      if (idx == 8) check("rpu_cken_e8", CK_EN, 1);
    end

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 299) == 0) begin
        rn_abort();
        repeat ($urandom_range(1, 3)) step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        rn_release();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
